// File: rtl/msf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msf_pkg
//  Purpose  : Shared types and constants for the MSF time-code decoder.
//             Holds the decoder state enum, the second indices of the fields
//             inside a 60-second MSF frame, and the end-of-minute marker.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package msf_pkg;

    // Decoder states
    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_CHECK   = 3'd2,
        ST_ARMED   = 3'd3,
        ST_DONE    = 3'd4
    } msf_state_e;

    // Second indices inside the frame (width matches the sec counter)
    localparam logic [5:0] HOUR_FIRST = 6'd39;
    localparam logic [5:0] MIN_FIRST  = 6'd45;
    localparam logic [5:0] TIME_LAST  = 6'd51;
    localparam logic [5:0] MARK_FIRST = 6'd52;
    localparam logic [5:0] PAR_TIME   = 6'd57;
    localparam logic [5:0] FRAME_LAST = 6'd59;

    // A-bits 52..59 of a well-formed frame
    localparam logic [7:0] MARKER     = 8'b0111_1110;

    // Width of the combined hour/minute field (A39..A51)
    localparam int unsigned TIME_W    = 13;

endpackage : msf_pkg
`default_nettype wire

// File: rtl/msf_bcd_range.sv
`default_nettype none
// ============================================================================
//  Module   : msf_bcd_range
//  Purpose  : Combinational range check of the 13-bit hour/minute BCD field
//             as received from the MSF A-bits 39..51 (MSB first).
//             Field layout: [12:11] hour tens, [10:7] hour units,
//                           [6:4]   min tens,  [3:0]  min units.
//  Ports    : field_i     - 13-bit BCD hour/minute field
//             in_range_o  - 1 when hours are 00..23 and minutes 00..59
//  Revision : 1.0 - initial release
// ============================================================================
module msf_bcd_range
    import msf_pkg::*;
(
    input  logic [TIME_W-1:0] field_i,
    output logic              in_range_o
);

    logic [1:0] w_hour_tens;
    logic [3:0] w_hour_units;
    logic [2:0] w_min_tens;
    logic [3:0] w_min_units;
    logic       w_hour_ok;
    logic       w_min_ok;

    assign w_hour_tens  = field_i[12:11];
    assign w_hour_units = field_i[10:7];
    assign w_min_tens   = field_i[6:4];
    assign w_min_units  = field_i[3:0];

    // Hours 00..19 allow any decimal unit, hours 2x stop at 23
    assign w_hour_ok = ((w_hour_tens < 2'd2) && (w_hour_units <= 4'd9)) ||
                       ((w_hour_tens == 2'd2) && (w_hour_units <= 4'd3));

    assign w_min_ok  = (w_min_tens <= 3'd5) && (w_min_units <= 4'd9);

    assign in_range_o = w_hour_ok && w_min_ok;

endmodule : msf_bcd_range
`default_nettype wire

// File: rtl/msf_time_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : msf_time_decoder
//  Purpose  : Assembles one 60-second MSF frame from the per-second A/B bits,
//             validates it (parity, end-of-minute marker, BCD range) and, at
//             the next minute marker, issues a one-cycle load strobe with the
//             decoded BCD hour/minute digits for the clock digit chain.
//  Ports    : clk_i, rst_ni          - clock, synchronous active-low reset
//             minute_i               - pulse at the start of second 0
//             bit_valid_i            - pulse per second 1..59, qualifies bits
//             a_bit_i, b_bit_i       - A/B bit of the current second
//             load_o                 - one-cycle digit load strobe
//             hour_tens_o/units_o    - BCD hours
//             min_tens_o/units_o     - BCD minutes
//             sync_o                 - high while not hunting
//             frame_ok_o             - result of the last frame check
//  Revision : 1.0 - initial release
// ============================================================================
module msf_time_decoder
    import msf_pkg::*;
#(
    parameter bit CHECK_MARKER = 1'b1
)
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       minute_i,
    input  logic       bit_valid_i,
    input  logic       a_bit_i,
    input  logic       b_bit_i,
    output logic       load_o,
    output logic [1:0] hour_tens_o,
    output logic [3:0] hour_units_o,
    output logic [2:0] min_tens_o,
    output logic [3:0] min_units_o,
    output logic       sync_o,
    output logic       frame_ok_o
);

    msf_state_e        state_q;
    logic [5:0]        sec_q;
    logic [TIME_W-1:0] time_q;
    logic [7:0]        mark_q;
    logic              par_q;      // running XOR of A39..A51
    logic              b57_q;
    logic              load_q;
    logic              sync_q;
    logic              frame_ok_q;
    logic [1:0]        hour_tens_q;
    logic [3:0]        hour_units_q;
    logic [2:0]        min_tens_q;
    logic [3:0]        min_units_q;

    logic [5:0]        w_sec_next;
    logic              w_in_time;
    logic              w_in_mark;
    logic              w_range_ok;
    logic              w_marker_ok;
    logic              w_parity_ok;
    logic              w_frame_valid;

    // The counter holds the index of the last accepted bit, so the incoming
    // bit belongs to sec_q + 1.
    assign w_sec_next = sec_q + 6'd1;
    assign w_in_time  = (w_sec_next >= HOUR_FIRST) && (w_sec_next <= TIME_LAST);
    assign w_in_mark  = (w_sec_next >= MARK_FIRST) && (w_sec_next <= FRAME_LAST);

    msf_bcd_range u_range (
        .field_i    (time_q),
        .in_range_o (w_range_ok)
    );

    if (CHECK_MARKER) begin : g_marker_on
        assign w_marker_ok = (mark_q == MARKER);
    end else begin : g_marker_off
        assign w_marker_ok = 1'b1;
    end

    // Odd parity over the time field plus B57
    assign w_parity_ok   = par_q ^ b57_q;
    assign w_frame_valid = w_parity_ok && w_marker_ok && w_range_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_HUNT;
            sec_q        <= 6'd0;
            time_q       <= '0;
            mark_q       <= 8'd0;
            par_q        <= 1'b0;
            b57_q        <= 1'b0;
            load_q       <= 1'b0;
            sync_q       <= 1'b0;
            frame_ok_q   <= 1'b0;
            hour_tens_q  <= 2'd0;
            hour_units_q <= 4'd0;
            min_tens_q   <= 3'd0;
            min_units_q  <= 4'd0;
        end else begin
            load_q <= 1'b0;

            case (state_q)
                ST_HUNT: begin
                    if (minute_i) begin
                        state_q <= ST_RECEIVE;
                        sync_q  <= 1'b1;
                        sec_q   <= 6'd0;
                        time_q  <= '0;
                        mark_q  <= 8'd0;
                        par_q   <= 1'b0;
                        b57_q   <= 1'b0;
                    end
                end

                ST_RECEIVE: begin
                    if (minute_i) begin
                        // Short frame: drop it and start over from second 0
                        frame_ok_q <= 1'b0;
                        sec_q      <= 6'd0;
                        time_q     <= '0;
                        mark_q     <= 8'd0;
                        par_q      <= 1'b0;
                        b57_q      <= 1'b0;
                    end else if (bit_valid_i) begin
                        sec_q <= w_sec_next;
                        if (w_in_time) begin
                            time_q <= {time_q[TIME_W-2:0], a_bit_i};
                            par_q  <= par_q ^ a_bit_i;
                        end
                        if (w_in_mark) begin
                            mark_q <= {mark_q[6:0], a_bit_i};
                        end
                        if (w_sec_next == PAR_TIME) begin
                            b57_q <= b_bit_i;
                        end
                        if (w_sec_next == FRAME_LAST) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    frame_ok_q <= w_frame_valid;
                    if (w_frame_valid) begin
                        state_q      <= ST_ARMED;
                        hour_tens_q  <= time_q[12:11];
                        hour_units_q <= time_q[10:7];
                        min_tens_q   <= time_q[6:4];
                        min_units_q  <= time_q[3:0];
                    end else begin
                        state_q <= ST_DONE;
                    end
                end

                ST_ARMED, ST_DONE: begin
                    if (minute_i) begin
                        load_q  <= (state_q == ST_ARMED);
                        state_q <= ST_RECEIVE;
                        sec_q   <= 6'd0;
                        time_q  <= '0;
                        mark_q  <= 8'd0;
                        par_q   <= 1'b0;
                        b57_q   <= 1'b0;
                    end else if (bit_valid_i) begin
                        // A 60th bit (leap second or lost marker): resync
                        state_q    <= ST_HUNT;
                        sync_q     <= 1'b0;
                        frame_ok_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_HUNT;
                    sync_q  <= 1'b0;
                end
            endcase
        end
    end

    assign load_o       = load_q;
    assign sync_o       = sync_q;
    assign frame_ok_o   = frame_ok_q;
    assign hour_tens_o  = hour_tens_q;
    assign hour_units_o = hour_units_q;
    assign min_tens_o   = min_tens_q;
    assign min_units_o  = min_units_q;

endmodule : msf_time_decoder
`default_nettype wire

// File: tb/tb_msf_time_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msf_time_decoder
//  Purpose  : Self-checking bench for msf_time_decoder. Expected digit loads
//             are queued when the releasing minute marker is driven and are
//             matched against every observed load_o strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msf_time_decoder;

    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b0;
    logic       minute_i    = 1'b0;
    logic       bit_valid_i = 1'b0;
    logic       a_bit_i     = 1'b0;
    logic       b_bit_i     = 1'b0;
    logic       load_o;
    logic [1:0] hour_tens_o;
    logic [3:0] hour_units_o;
    logic [2:0] min_tens_o;
    logic [3:0] min_units_o;
    logic       sync_o;
    logic       frame_ok_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_loads  = 0;
    logic [12:0] exp_q[$];
    logic [12:0] mon_exp;
    logic [12:0] w_digits;

    msf_time_decoder #(.CHECK_MARKER(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .minute_i     (minute_i),
        .bit_valid_i  (bit_valid_i),
        .a_bit_i      (a_bit_i),
        .b_bit_i      (b_bit_i),
        .load_o       (load_o),
        .hour_tens_o  (hour_tens_o),
        .hour_units_o (hour_units_o),
        .min_tens_o   (min_tens_o),
        .min_units_o  (min_units_o),
        .sync_o       (sync_o),
        .frame_ok_o   (frame_ok_o)
    );

    always #5 clk_i = ~clk_i;

    assign w_digits = {hour_tens_o, hour_units_o, min_tens_o, min_units_o};

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] enc(input int ht, input int hu, input int mt, input int mu);
        return {ht[1:0], hu[3:0], mt[2:0], mu[3:0]};
    endfunction

    // Scoreboard side: every strobe must match the oldest queued expectation
    always @(posedge clk_i) begin
        #1;
        if (load_o === 1'b1) begin
            n_loads++;
            if (exp_q.size() == 0) begin
                chk_eq("load_unexpected", 32'(load_o), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk_eq("load_digits", 32'(w_digits), 32'(mon_exp));
            end
        end
    end

    task automatic pulse_minute(input logic with_bit);
        @(negedge clk_i);
        minute_i    = 1'b1;
        bit_valid_i = with_bit;
        a_bit_i     = 1'($urandom);
        b_bit_i     = 1'($urandom);
        @(negedge clk_i);
        minute_i    = 1'b0;
        bit_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic send_bit(input logic a, input logic b);
        @(negedge clk_i);
        bit_valid_i = 1'b1;
        a_bit_i     = a;
        b_bit_i     = b;
        @(negedge clk_i);
        bit_valid_i = 1'b0;
    endtask

    // Seconds 1..nbits of a frame carrying time field t and B57 = b57
    task automatic send_bits(input logic [12:0] t, input logic b57, input int nbits);
        logic [7:0] mk;
        logic       a;
        logic       b;
        mk = 8'b0111_1110;
        for (int s = 1; s <= nbits; s++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            if (s >= 39 && s <= 51) a = t[51 - s];
            if (s >= 52 && s <= 59) a = mk[59 - s];
            if (s == 57)            b = b57;
            send_bit(a, b);
        end
    endtask

    // Full 59-bit frame with odd parity (optionally broken), then the CHECK cycle
    task automatic send_frame(input logic [12:0] t, input logic bad_par);
        send_bits(t, ~(^t) ^ bad_par, 59);
        @(negedge clk_i);
    endtask

    task automatic chk_cleared(input string tag);
        chk_eq({tag, "_load"},     32'(load_o),     32'd0);
        chk_eq({tag, "_digits"},   32'(w_digits),   32'd0);
        chk_eq({tag, "_sync"},     32'(sync_o),     32'd0);
        chk_eq({tag, "_frame_ok"}, 32'(frame_ok_o), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk_cleared("reset");
        rst_ni = 1'b1;

        pulse_minute(1'b0);
        chk_eq("sync_after_minute", 32'(sync_o), 32'd1);

        // 14:37 good frame
        send_frame(enc(1, 4, 3, 7), 1'b0);
        chk_eq("f1437_ok",     32'(frame_ok_o), 32'd1);
        chk_eq("f1437_digits", 32'(w_digits),   32'(enc(1, 4, 3, 7)));
        exp_q.push_back(enc(1, 4, 3, 7));
        pulse_minute(1'b0);
        chk_eq("f1437_loads",  n_loads, 32'd1);

        // Parity error: digits hold, no load
        send_frame(enc(1, 4, 3, 7), 1'b1);
        chk_eq("par_ok",     32'(frame_ok_o), 32'd0);
        chk_eq("par_digits", 32'(w_digits),   32'(enc(1, 4, 3, 7)));
        pulse_minute(1'b0);
        chk_eq("par_loads",  n_loads, 32'd1);

        // Hours 25 with correct parity
        send_frame(enc(2, 5, 0, 0), 1'b0);
        chk_eq("range_ok",     32'(frame_ok_o), 32'd0);
        chk_eq("range_digits", 32'(w_digits),   32'(enc(1, 4, 3, 7)));
        pulse_minute(1'b0);
        chk_eq("range_loads",  n_loads, 32'd1);

        // Good 09:05 so the short frame has a set frame_ok to clear
        send_frame(enc(0, 9, 0, 5), 1'b0);
        chk_eq("f0905_ok", 32'(frame_ok_o), 32'd1);
        exp_q.push_back(enc(0, 9, 0, 5));
        pulse_minute(1'b0);
        chk_eq("f0905_loads", n_loads, 32'd2);

        // Short frame after 40 bits, then 23:59
        send_bits(enc(1, 1, 1, 1), 1'b0, 40);
        pulse_minute(1'b0);
        chk_eq("short_ok",    32'(frame_ok_o), 32'd0);
        chk_eq("short_sync",  32'(sync_o),     32'd1);
        chk_eq("short_loads", n_loads,         32'd2);
        send_frame(enc(2, 3, 5, 9), 1'b0);
        chk_eq("f2359_ok",     32'(frame_ok_o), 32'd1);
        chk_eq("f2359_digits", 32'(w_digits),   32'(enc(2, 3, 5, 9)));
        exp_q.push_back(enc(2, 3, 5, 9));
        pulse_minute(1'b0);
        chk_eq("f2359_loads",  n_loads, 32'd3);

        // Long frame: 60th bit while armed
        send_frame(enc(1, 2, 0, 0), 1'b0);
        chk_eq("long_armed_ok", 32'(frame_ok_o), 32'd1);
        send_bit(1'b0, 1'b0);
        chk_eq("long_sync", 32'(sync_o),     32'd0);
        chk_eq("long_ok",   32'(frame_ok_o), 32'd0);
        pulse_minute(1'b0);
        chk_eq("long_loads",       n_loads,         32'd3);
        chk_eq("long_resync",      32'(sync_o),     32'd1);
        chk_eq("long_digits_hold", 32'(w_digits),   32'(enc(1, 2, 0, 0)));

        // Reset at second 30
        send_bits(enc(0, 0, 0, 0), 1'b0, 30);
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_cleared("midreset");

        // Minute+bit together: only the minute counts, in HUNT and in RECEIVE
        pulse_minute(1'b1);
        chk_eq("coinc_sync", 32'(sync_o), 32'd1);
        send_bits(enc(0, 0, 0, 0), 1'b0, 20);
        pulse_minute(1'b1);
        send_frame(enc(0, 7, 4, 5), 1'b0);
        chk_eq("f0745_ok", 32'(frame_ok_o), 32'd1);
        exp_q.push_back(enc(0, 7, 4, 5));
        pulse_minute(1'b0);
        chk_eq("f0745_loads", n_loads, 32'd4);

        // Reset in the same cycle as the releasing minute marker
        send_frame(enc(2, 0, 1, 0), 1'b0);
        chk_eq("f2010_ok", 32'(frame_ok_o), 32'd1);
        @(negedge clk_i);
        rst_ni   = 1'b0;
        minute_i = 1'b1;
        @(negedge clk_i);
        minute_i = 1'b0;
        @(negedge clk_i);
        rst_ni   = 1'b1;
        @(negedge clk_i);
        chk_cleared("armreset");
        chk_eq("armreset_loads", n_loads, 32'd4);

        repeat (3) @(negedge clk_i);
        chk_eq("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_msf_time_decoder
`default_nettype wire

// File: doc/msf_time_decoder.md
# msf_time_decoder

Receives the per-second MSF bit stream from the bit demodulator, assembles one 60-second frame, validates it, and produces a one-cycle `load_o` strobe with BCD hour/minute digit values at the start of the next minute. It is the writer for the clock's digit chain: `load_o` and the digit values drive the `load_i`/`load_value_i` ports of the hour and minute digit counters. Seconds digits load 0 on the same strobe.

## Interface

Parameters:
- `CHECK_MARKER`, default 1: when 1, A-bits 52..59 must equal 0111_1110 for a frame to be valid; when 0, these bits are ignored.

Ports:
- `clk_i` input 1: system clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `minute_i` input 1: one-cycle pulse marking the start of second 0.
- `bit_valid_i` input 1: one-cycle pulse, one per second (seconds 1..59); qualifies `a_bit_i`/`b_bit_i`.
- `a_bit_i` input 1: A bit for the current second.
- `b_bit_i` input 1: B bit for the current second.
- `load_o` output 1: one-cycle strobe; digit outputs are valid in this cycle.
- `hour_tens_o` output 2: BCD hours tens, 0..2.
- `hour_units_o` output 4: BCD hours units, 0..9.
- `min_tens_o` output 3: BCD minutes tens, 0..5.
- `min_units_o` output 4: BCD minutes units, 0..9.
- `sync_o` output 1: high while state is not HUNT.
- `frame_ok_o` output 1: result of the last completed frame check; held until the next check.

## Operation

- `sec` counter: 6 bits, 0..59. It is the second number of the most recently accepted bit.
- States:
  - HUNT: idle. `minute_i` → RECEIVE, `sec`=0.
  - RECEIVE: each `bit_valid_i` increments `sec`, then captures the bit at the new index.
    - Bits at A39..A51 are shifted into a 13-bit time register, MSB first.
    - `b_bit_i` is captured at `sec`=57.
    - A-bits 52..59 are shifted into an 8-bit marker register.
    - A running XOR covers A39..A51 plus B57.
  - CHECK: a single cycle entered after the `sec`=59 capture. The frame is valid when all of these hold:
    - Parity is odd: the XOR of A39..A51 and B57 equals 1.
    - The marker check passes, when enabled.
    - Hours are 00..23 and minutes are 00..59, with each unit nibble ≤ 9.
  - CHECK outcome: `frame_ok_o` takes the result. A valid frame goes to ARMED. An invalid frame goes to DONE.
  - ARMED: holds the decoded digits. `minute_i` → `load_o`=1, then RECEIVE with `sec`=0.
  - DONE: `minute_i` → RECEIVE with `sec`=0 and no load.
- Boundary conditions:
  - `minute_i` in RECEIVE with `sec`<59 is a short frame. The partial frame is discarded, `frame_ok_o` goes to 0, and the block restarts RECEIVE with `sec`=0. No load.
  - `bit_valid_i` in ARMED or DONE is a long frame, e.g. a leap second. State → HUNT, `frame_ok_o`=0, no load.
  - `minute_i` and `bit_valid_i` in the same cycle: `minute_i` wins and the bit is dropped.
  - Reset has priority over every event, including mid-frame and in the cycle of `minute_i` while ARMED. No load is issued.
- Digit outputs are updated only on the CHECK→ARMED transition. Otherwise they hold their last loaded value.

## Timing

- Reset values: state HUNT, `sec`=0, `load_o`=0, all digit outputs 0, `sync_o`=0, `frame_ok_o`=0.
- All outputs are registered.
- `load_o` is high in the cycle after the `minute_i` cycle, for exactly one cycle.
- `frame_ok_o` and the digit outputs update two cycles after the `bit_valid_i` for second 59: one cycle of capture, then CHECK.
- Digit outputs are stable from entry to ARMED through the `load_o` cycle.
- Inputs are assumed synchronous to `clk_i` and at least 2 cycles apart. Pulses arriving closer than that are still processed, per the priority rules above.

## Structure

- Shared package `msf_pkg`:
  - State enum.
  - Bit indices: `HOUR_FIRST`=39, `MIN_FIRST`=45, `TIME_LAST`=51, `PAR_TIME`=57, `MARK_FIRST`=52, `FRAME_LAST`=59.
  - `MARKER`=8'b0111_1110.
- One sub-module, `msf_bcd_range`: combinational range check of the 13-bit hour/minute field. It lives in its own file so that date decoding can reuse the same pattern.

## Test plan

- 14:37 frame:
  - Stimulus: `minute_i`, then 59 bits. A39..44=010100, A45..51=0110111, B57=0, marker 01111110. Then `minute_i`.
  - Response: one `load_o` pulse with digits 1/4/3/7; `frame_ok_o`=1.
- Parity error: same frame with B57=1 → `frame_ok_o`=0, no `load_o`, digit outputs keep their previous values.
- Out-of-range time: hours encoded 0x25 with correct parity → no load, `frame_ok_o`=0.
- Short frame: `minute_i` after 40 bits → no load, `sec` restarts at 0. A following good 23:59 frame then loads 2/3/5/9.
- Long frame: a 60th `bit_valid_i` while ARMED → HUNT, `sync_o`=0, no load on the next `minute_i`.
- Reset mid-frame: `rst_ni`=0 at second 30, then released → all outputs 0 and HUNT. A simultaneous `minute_i`+`bit_valid_i` pair is then treated as the minute marker only.
